sha3_absorb_loader: RTL

- Reader end of the 64-bit message FIFO. Pops message lanes and assembles RATE_LANES-lane rate blocks.
- Applies SHA3 pad10*1 with domain byte 0x06 on the final block.
- Hands each block to the Keccak absorb stage over a valid/ready handshake.
- Sits between the input FIFO and the permutation core.

---
 rtl/sha3_pkg.sv | 21 ++
 rtl/sha3_pad_lane.sv | 25 ++
 rtl/sha3_absorb_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3 absorb path.
package sha3_pkg;

  localparam int unsigned LANE_W         = 64;
  localparam int unsigned RATE_LANES_256 = 17;
  localparam int unsigned RATE_BYTES     = 136;

  localparam logic [7:0] DS_SHA3 = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    PAD,
    EMIT
  } loader_state_t;

  typedef logic [63:0] lane_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Applies pad10*1 to one lane: mask bytes at and above r, insert the domain
// byte at r on the partial lane, and set the closing 0x80 on the top lane.
module sha3_pad_lane
  import sha3_pkg::*;
(
  input  lane_t      lane,
  input  logic [2:0] r,
  input  logic       is_pad_lane,
  input  logic       is_last_lane,
  output lane_t      padded
);

  // Byte-wise mask and XOR; both pad bytes may land on the same byte (0x86).
  always_comb begin
    padded = lane;
    if (is_pad_lane) begin
      for (int b = 0; b < 8; b++) begin
        if (3'(b) >= r) padded[8*b +: 8] = 8'h00;
        if (3'(b) == r) padded[8*b +: 8] = padded[8*b +: 8] ^ DS_SHA3;
      end
    end
    if (is_last_lane) padded[63:56] = padded[63:56] ^ PAD_END;
  end

endmodule

// File: rtl/sha3_absorb_loader.sv
// Pops message lanes from the FIFO, assembles rate blocks, pads the final
// block and hands blocks to the absorb stage over valid/ready.
module sha3_absorb_loader #(
  parameter int unsigned LANE_W     = 64,
  parameter int unsigned RATE_LANES = 17,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             msg_len,
  output logic                         busy,
  output logic                         done,
  input  logic [LANE_W-1:0]            fifo_data,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  output logic [RATE_LANES*LANE_W-1:0] blk_data,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic                         blk_last
);

  import sha3_pkg::loader_state_t;
  import sha3_pkg::lane_t;
  import sha3_pkg::IDLE;
  import sha3_pkg::FILL;
  import sha3_pkg::DRAIN;
  import sha3_pkg::PAD;
  import sha3_pkg::EMIT;

  localparam int unsigned CNT_W     = $clog2(RATE_LANES + 1);
  localparam int unsigned BLK_BYTES = RATE_LANES * LANE_W / 8;

  loader_state_t state, state_nxt;

  lane_t             lanes     [RATE_LANES];
  lane_t             lanes_pad [RATE_LANES];
  logic [LEN_W-1:0]  rem_bytes;
  logic [LEN_W-1:0]  blk_bytes;
  logic [LEN_W-1:0]  rem_after;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  captured;
  logic [CNT_W-1:0]  blk_lanes;
  logic              cap_pending;
  logic              last_q;
  logic              done_q;
  logic              more_blocks;

  // Lanes needed for the current block and the bytes it consumes.
  always_comb begin
    more_blocks = (rem_bytes >= LEN_W'(BLK_BYTES));
    if (more_blocks) begin
      blk_lanes = CNT_W'(RATE_LANES);
    end else begin
      blk_lanes = CNT_W'(rem_bytes >> 3) + CNT_W'(|rem_bytes[2:0]);
    end
    blk_bytes = LEN_W'({blk_lanes, 3'b000});
    rem_after = (rem_bytes > blk_bytes) ? (rem_bytes - blk_bytes) : '0;
  end

  // Padded view of every lane, used only when the final block is formed.
  for (genvar i = 0; i < RATE_LANES; i++) begin : g_pad
    sha3_pad_lane u_pad (
      .lane         (lanes[i]),
      .r            (rem_bytes[2:0]),
      .is_pad_lane  ((rem_bytes >> 3) == LEN_W'(i)),
      .is_last_lane (i == RATE_LANES - 1),
      .padded       (lanes_pad[i])
    );
    assign blk_data[i*LANE_W +: LANE_W] = lanes[i];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (issued == blk_lanes) state_nxt = DRAIN;
      DRAIN:   if (captured == blk_lanes) state_nxt = more_blocks ? EMIT : PAD;
      PAD:     state_nxt = EMIT;
      EMIT:    if (blk_ready) state_nxt = last_q ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    fifo_rd_en = 1'b0;
    blk_valid  = 1'b0;
    busy       = (state != IDLE);
    done       = done_q;
    blk_last   = last_q;
    if (state == FILL)  fifo_rd_en = !fifo_empty && (issued < blk_lanes);
    if (state == EMIT)  blk_valid  = 1'b1;
  end

  // Datapath: pop/capture counters, lane storage, remaining length, flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
      rem_bytes   <= '0;
      issued      <= '0;
      captured    <= '0;
      cap_pending <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cap_pending <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + CNT_W'(1);
      if (cap_pending) begin
        lanes[captured] <= fifo_data;
        captured        <= captured + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            rem_bytes <= msg_len;
            issued    <= '0;
            captured  <= '0;
            last_q    <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
          end
        end
        PAD: begin
          for (int i = 0; i < RATE_LANES; i++) lanes[i] <= lanes_pad[i];
          last_q <= 1'b1;
        end
        EMIT: begin
          if (blk_ready) begin
            rem_bytes <= rem_after;
            issued    <= '0;
            captured  <= '0;
            last_q    <= 1'b0;
            done_q    <= last_q;
            for (int i = 0; i < RATE_LANES; i++) lanes[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
